// File: rtl/pipe_dbg_pkg.sv
// Shared types and constants for the pipeline step sequencer.
package pipe_dbg_pkg;

  localparam int CNT_W = 8;
  localparam int REM_W = 5;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // A burst length of zero on the switches stands for the longest burst.
  localparam logic [REM_W-1:0] BURST_ZERO_LEN = 5'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_BURST,
    S_RUN,
    S_REFR
  } state_e;

  function automatic logic [REM_W-1:0] burst_count(input logic [3:0] len);
    return (len == 4'd0) ? BURST_ZERO_LEN : {1'b0, len};
  endfunction

endpackage

// File: rtl/pipe_step_ctrl_edge_rise.sv
// Registers a debounced button level and flags its rising edge for one CCLK.
module edge_rise (
  input  logic CCLK,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sample_q;
  logic prev_q;

  // Sample the button once, then keep the previous sample for edge compare.
  always_ff @(posedge CCLK) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= din;
      prev_q   <= sample_q;
    end
  end

  assign rise = sample_q & ~prev_q;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Front-panel sequencer: turns button activity into pipeline advance/clear
// pulses (single, burst, free-run) and pairs every advance with one LCD
// refresh via a req/ack handshake.
module pipe_step_ctrl
  import pipe_dbg_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int RUN_DIV = 5000000
) (
  input  logic             CCLK,
  input  logic             rst_n,
  input  logic             step_btn,
  input  logic             clr_btn,
  input  logic [1:0]       mode,
  input  logic [3:0]       burst_len,
  input  logic [3:0]       sw,
  input  logic             disp_ack,
  output logic             pipe_en,
  output logic             pipe_clr,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic             disp_req,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  state_e           state;
  state_e           ret_state;
  logic [REM_W-1:0] remaining;
  logic [DIV_W-1:0] div_cnt;
  logic             pending;
  logic [3:0]       sw_shadow;
  logic             step_rise;
  logic             clr_rise;
  logic             step_go;

  edge_rise u_step_edge (
    .CCLK  (CCLK),
    .rst_n (rst_n),
    .din   (step_btn),
    .rise  (step_rise)
  );

  edge_rise u_clr_edge (
    .CCLK  (CCLK),
    .rst_n (rst_n),
    .din   (clr_btn),
    .rise  (clr_rise)
  );

  // A step request parked during a refresh counts as a fresh press in IDLE.
  assign step_go = step_rise | pending;

  // Sequencer FSM with registered pulse, counter and handshake outputs.
  always_ff @(posedge CCLK) begin
    // NOTE: every register here uses <= so all branches see the pre-edge
    // values; a blocking assignment would leak new values into later logic.
    if (!rst_n) begin
      state     <= S_IDLE;
      ret_state <= S_IDLE;
      remaining <= '0;
      div_cnt   <= '0;
      pending   <= 1'b0;
      sw_shadow <= sw;
      pipe_en   <= 1'b0;
      pipe_clr  <= 1'b0;
      cyc_cnt   <= '0;
      disp_req  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pipe_en  <= 1'b0;
      pipe_clr <= 1'b0;

      if (clr_rise) begin
        // Clear wins over everything, including a same-cycle step press.
        // An outstanding request is left up so a single ack retires it.
        pipe_clr  <= 1'b1;
        cyc_cnt   <= '0;
        pending   <= 1'b0;
        div_cnt   <= '0;
        remaining <= '0;
        ret_state <= S_IDLE;
        state     <= S_REFR;
        sw_shadow <= sw;
        busy      <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            pending <= 1'b0;
            if (step_go && mode == MODE_SINGLE) begin
              state <= S_STEP;
              busy  <= 1'b1;
            end else if (step_go && mode == MODE_BURST) begin
              remaining <= burst_count(burst_len);
              state     <= S_BURST;
              busy      <= 1'b1;
            end else if (step_go && mode == MODE_RUN) begin
              div_cnt <= '0;
              state   <= S_RUN;
              busy    <= 1'b1;
            end else if (sw != sw_shadow) begin
              sw_shadow <= sw;
              ret_state <= S_IDLE;
              state     <= S_REFR;
              busy      <= 1'b1;
            end else begin
              busy <= 1'b0;
            end
          end

          S_STEP: begin
            pipe_en   <= 1'b1;
            cyc_cnt   <= cyc_cnt + 1'b1;
            ret_state <= S_IDLE;
            sw_shadow <= sw;
            state     <= S_REFR;
          end

          S_BURST: begin
            pipe_en   <= 1'b1;
            cyc_cnt   <= cyc_cnt + 1'b1;
            remaining <= remaining - 1'b1;
            ret_state <= (remaining != 5'd1) ? S_BURST : S_IDLE;
            sw_shadow <= sw;
            state     <= S_REFR;
          end

          S_RUN: begin
            if (step_rise || mode != MODE_RUN) begin
              div_cnt <= '0;
              state   <= S_IDLE;
              busy    <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
              div_cnt   <= '0;
              pipe_en   <= 1'b1;
              cyc_cnt   <= cyc_cnt + 1'b1;
              ret_state <= S_RUN;
              sw_shadow <= sw;
              state     <= S_REFR;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end

          S_REFR: begin
            if (step_rise) begin
              pending <= 1'b1;
            end
            if (!disp_req) begin
              disp_req <= 1'b1;
            end else if (disp_ack) begin
              disp_req <= 1'b0;
              state    <= ret_state;
              busy     <= (ret_state != S_IDLE);
            end
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl: single step, burst, burst wrap, clear
// abort, sw-triggered refresh with pending step, free-run, hold and reset.
module tb_pipe_step_ctrl;
  import pipe_dbg_pkg::*;

  localparam int DIV_W   = 24;
  localparam int RUN_DIV = 4;

  logic       CCLK      = 1'b0;
  logic       rst_n     = 1'b0;
  logic       step_btn  = 1'b0;
  logic       clr_btn   = 1'b0;
  logic [1:0] mode      = MODE_SINGLE;
  logic [3:0] burst_len = 4'd0;
  logic [3:0] sw        = 4'd0;
  logic       disp_ack  = 1'b0;
  logic       pipe_en;
  logic       pipe_clr;
  logic [7:0] cyc_cnt;
  logic       disp_req;
  logic       busy;

  pipe_step_ctrl #(.DIV_W(DIV_W), .RUN_DIV(RUN_DIV)) dut (
    .CCLK      (CCLK),
    .rst_n     (rst_n),
    .step_btn  (step_btn),
    .clr_btn   (clr_btn),
    .mode      (mode),
    .burst_len (burst_len),
    .sw        (sw),
    .disp_ack  (disp_ack),
    .pipe_en   (pipe_en),
    .pipe_clr  (pipe_clr),
    .cyc_cnt   (cyc_cnt),
    .disp_req  (disp_req),
    .busy      (busy)
  );

  always #5 CCLK = ~CCLK;

  int n_cmp = 0;
  int n_bad = 0;

  // Posedge count; cyc == k after the k-th rising edge.
  int cyc = 0;
  always @(posedge CCLK) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  int   en_cnt = 0, clr_cnt = 0, overlap = 0;
  int   en_cyc = 0, en_prev_cyc = 0;
  int   req_hi_cnt = 0, req_rise_cnt = 0, req_rise_cyc = 0;
  logic req_prev = 1'b0;
  always @(negedge CCLK) begin
    req_prev <= disp_req;
    if (pipe_en === 1'b1) begin
      en_cnt      <= en_cnt + 1;
      en_prev_cyc <= en_cyc;
      en_cyc      <= cyc;
    end
    if (pipe_clr === 1'b1) clr_cnt <= clr_cnt + 1;
    if (pipe_en === 1'b1 && pipe_clr === 1'b1) overlap <= overlap + 1;
    if (disp_req === 1'b1) req_hi_cnt <= req_hi_cnt + 1;
    if (disp_req === 1'b1 && req_prev !== 1'b1) begin
      req_rise_cnt <= req_rise_cnt + 1;
      req_rise_cyc <= cyc;
    end
  end

  // LCD updater model: ack either tied high or raised ack_delay cycles
  // after req, held until req drops.
  logic ack_tie   = 1'b0;
  int   ack_delay = 2;
  int   req_age   = 0;
  initial begin
    forever begin
      @(negedge CCLK);
      if (ack_tie) begin
        disp_ack = 1'b1;
      end else begin
        if (disp_req === 1'b1) req_age = req_age + 1;
        else req_age = 0;
        disp_ack = (disp_req === 1'b1) && (req_age >= ack_delay + 1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CCLK);
    #1;
  endtask

  task automatic press_step(output int press_cyc);
    press_cyc = cyc;
    step_btn  = 1'b1;
    repeat (3) tick();
    step_btn  = 1'b0;
  endtask

  task automatic press_clr();
    clr_btn = 1'b1;
    repeat (3) tick();
    clr_btn = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int quiet = 0;
    for (int i = 0; i < max_cyc && quiet < 3; i++) begin
      tick();
      if (busy === 1'b0 && disp_req === 1'b0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check(tag, 0, 1);
  endtask

  task automatic wait_en(input string tag, input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && en_cnt < target; i++) tick();
    if (en_cnt < target) check(tag, en_cnt, target);
  endtask

  task automatic wait_req(input string tag, input logic lvl, input int max_cyc);
    for (int i = 0; i < max_cyc && disp_req !== lvl; i++) tick();
    if (disp_req !== lvl) check(tag, disp_req, lvl);
  endtask

  int pc, e0, c0, r0, rr0;

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_pipe_en", pipe_en, 0);
    check("rst_pipe_clr", pipe_clr, 0);
    check("rst_cyc_cnt", cyc_cnt, 0);
    check("rst_disp_req", disp_req, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single step, ack two cycles after req
    mode = MODE_SINGLE; ack_tie = 1'b0; ack_delay = 2;
    e0 = en_cnt; r0 = req_hi_cnt;
    press_step(pc);
    wait_idle("step_idle_tmo", 60);
    check("step_en_count", en_cnt - e0, 1);
    check("step_en_latency", en_cyc - pc, 3);
    check("step_req_latency", req_rise_cyc - pc, 4);
    check("step_req_width", req_hi_cnt - r0, 3);
    check("step_cyc_cnt", cyc_cnt, 1);
    check("step_busy", busy, 0);

    // Burst of 3, ack tied high
    mode = MODE_BURST; burst_len = 4'd3; ack_tie = 1'b1;
    e0 = en_cnt;
    press_step(pc);
    wait_idle("burst_idle_tmo", 100);
    check("burst_en_count", en_cnt - e0, 3);
    check("burst_spacing", en_cyc - en_prev_cyc, 3);
    check("burst_cyc_cnt", cyc_cnt, 4);
    check("burst_busy", busy, 0);

    // Clear, then build cyc_cnt up to 250, then a 16-step burst wraps it
    c0 = clr_cnt;
    press_clr();
    wait_idle("clr_idle_tmo", 60);
    check("clr_pulse_count", clr_cnt - c0, 1);
    check("clr_cyc_cnt", cyc_cnt, 0);
    for (int b = 0; b < 16; b++) begin
      burst_len = (b < 15) ? 4'd0 : 4'd10;
      press_step(pc);
      wait_idle("fill_idle_tmo", 200);
    end
    check("fill_cyc_cnt", cyc_cnt, 250);
    burst_len = 4'd0;
    e0 = en_cnt;
    press_step(pc);
    wait_idle("wrap_idle_tmo", 200);
    check("wrap_en_count", en_cnt - e0, 16);
    check("wrap_cyc_cnt", cyc_cnt, 10);

    // Clear and step pressed together after the 2nd pulse of a 5-burst
    burst_len = 4'd5;
    e0 = en_cnt; c0 = clr_cnt;
    press_step(pc);
    wait_en("abort_en_tmo", e0 + 2, 60);
    step_btn = 1'b1; clr_btn = 1'b1;
    repeat (3) tick();
    step_btn = 1'b0; clr_btn = 1'b0;
    wait_idle("abort_idle_tmo", 60);
    repeat (10) tick();
    check("abort_en_count", en_cnt - e0, 2);
    check("abort_clr_count", clr_cnt - c0, 1);
    check("abort_cyc_cnt", cyc_cnt, 0);
    check("abort_busy", busy, 0);

    // sw change starts a refresh; a step during it runs once afterwards
    mode = MODE_SINGLE; ack_tie = 1'b0; ack_delay = 3;
    e0 = en_cnt; rr0 = req_rise_cnt;
    sw = 4'd5; step_btn = 1'b1;
    repeat (2) tick();
    check("sw_req_raised", disp_req, 1);
    check("sw_no_en", en_cnt - e0, 0);
    tick();
    step_btn = 1'b0;
    wait_idle("sw_idle_tmo", 80);
    check("sw_pending_en", en_cnt - e0, 1);
    check("sw_req_count", req_rise_cnt - rr0, 2);
    check("sw_cyc_cnt", cyc_cnt, 1);

    // Free-run, divider 4, ack five cycles late: period 4 + 7
    mode = MODE_RUN; ack_delay = 5;
    e0 = en_cnt;
    press_step(pc);
    wait_en("run_en_tmo", e0 + 2, 100);
    check("run_period", en_cyc - en_prev_cyc, 11);
    wait_req("run_req_hi_tmo", 1'b1, 20);
    wait_req("run_req_lo_tmo", 1'b0, 20);
    press_step(pc);
    wait_idle("run_stop_tmo", 60);
    repeat (30) tick();
    check("run_stop_en_count", en_cnt - e0, 2);
    check("run_cyc_cnt", cyc_cnt, 3);
    check("run_busy", busy, 0);

    // Hold mode ignores step presses
    mode = MODE_HOLD;
    e0 = en_cnt;
    press_step(pc);
    repeat (10) tick();
    check("hold_en_count", en_cnt - e0, 0);
    check("hold_busy", busy, 0);

    // Reset in the middle of a handshake
    mode = MODE_SINGLE; ack_delay = 5;
    press_step(pc);
    wait_req("mid_req_tmo", 1'b1, 20);
    rst_n = 1'b0;
    tick();
    check("midrst_disp_req", disp_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cyc_cnt", cyc_cnt, 0);
    check("midrst_pipe_en", pipe_en, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    check("en_clr_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
